lite_write_slave: RTL and testbench
===================================

Name: lite_write_slave

Overview:
- AXI-Lite write responder that terminates writes issued by the DMA's AXI-Lite write master.
- Accepts address (AW) and data (W) channels independently, in either order or in the same cycle.
- Commits the word into an internal register bank, then returns a write response on B.
- Exports the register bank and a one-cycle write strobe so the DMA core can consume control/config words.

Parameters:
- ADDR_W, 10, AW address width in bits (byte address).
- NUM_REGS, 16, number of 32-bit registers; word index = awaddr[ADDR_W-1:2].
- RESET_VAL, 32'h0000_0000, reset value loaded into every register.

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- s_axi_lite_awaddr  in  ADDR_W  write address
- s_axi_lite_awvalid  in  1  address valid
- s_axi_lite_awready  out  1  address ready
- s_axi_lite_wdata  in  32  write data
- s_axi_lite_wvalid  in  1  data valid
- s_axi_lite_wready  out  1  data ready
- s_axi_lite_bresp  out  2  response: 2'b00 OKAY, 2'b10 SLVERR
- s_axi_lite_bvalid  out  1  response valid
- s_axi_lite_bready  in  1  response ready
- reg_wr_en  out  1  one-cycle pulse when a register is written
- reg_wr_idx  out  $clog2(NUM_REGS)  index written (valid with reg_wr_en)
- reg_wr_data  out  32  data written (valid with reg_wr_en)
- regs_flat  out  NUM_REGS*32  register bank; reg i at bits [32*i+31:32*i]

Behaviour:
- Reset (rst_n=0, async assert, sync deassert by system): state=IDLE, aw_got=0, w_got=0, awready=0, wready=0, bvalid=0, bresp=2'b00, reg_wr_en=0, reg_wr_idx=0, reg_wr_data=0, every register=RESET_VAL.
- States (one-hot): IDLE, COMMIT, RESP.
- IDLE:
  - awready = !aw_got; wready = !w_got (combinational from state/flags).
  - AW handshake (awvalid&awready) latches awaddr and sets aw_got.
  - W handshake latches wdata and sets w_got.
  - Both handshakes may complete in the same cycle.
  - When aw_got&w_got are both set (registered), go to COMMIT on the next edge. Earliest path: simultaneous handshakes at cycle N, COMMIT at N+1, bvalid at N+2.
- COMMIT (exactly 1 cycle, awready=wready=0):
  - idx = addr[ADDR_W-1:2].
  - If idx < NUM_REGS and addr[1:0]==0: write register, pulse reg_wr_en=1 with reg_wr_idx/reg_wr_data, set bresp=OKAY.
  - Otherwise: no write, reg_wr_en stays 0, bresp=SLVERR.
  - Clear aw_got/w_got; go to RESP.
- RESP: bvalid=1 with bresp held stable until bvalid&bready. Then bvalid=0 and go to IDLE; ready to accept again the next cycle. If bready is already high on entry, RESP lasts 1 cycle.
- Only one outstanding transaction: no new AW/W is accepted in COMMIT or RESP. A second AW while one is latched in IDLE is stalled (awready=0) until the response completes; same for W.
- Register writes occur only in COMMIT; regs_flat is updated the cycle after COMMIT.
- Reset mid-transaction: all flags and the handshake drop immediately. Registers return to RESET_VAL and no response is issued.
- Unused address bits above the index range are checked: any nonzero bit that makes idx >= NUM_REGS gives SLVERR.

Optional Feature:
- Macro: LITE_WRITE_SLAVE_WSTRB_EN.
- With it defined:
  - Extra port s_axi_lite_wstrb, in, 4, byte enables, latched with wdata.
  - COMMIT updates only bytes whose strobe is 1; reg_wr_data shows the merged register value.
  - wstrb=4'b0000 with a valid address: no register change, reg_wr_en=0, bresp=OKAY.
- Without it: no wstrb port; every write replaces the full 32-bit word.

Test Plan:
- AW then W: awaddr=10'h008 at cycle 0, wdata=32'hDEAD_BEEF at cycle 3, bready=1 -> reg_wr_en pulse with idx=2; regs_flat[95:64]=32'hDEAD_BEEF; bvalid with bresp=00 exactly 2 cycles after the W handshake.
- W before AW, then same-cycle AW+W: addr 10'h000 data 32'h1 -> reg0=1 and bresp=00. Next, simultaneous handshakes at cycle N -> bvalid at N+2.
- Out of range: awaddr=10'h040 (idx 16, NUM_REGS=16), wdata=32'hFFFF_FFFF -> no reg_wr_en, all regs unchanged, bresp=2'b10. Misaligned awaddr=10'h005 -> bresp=2'b10.
- B backpressure: bready=0 for 5 cycles -> bvalid and bresp held stable, awready=wready=0 throughout; bready=1 -> bvalid drops the next cycle and awready=1.
- Back-to-back writes of 8 registers, addresses 0x00–0x1C, data=idx*32'h1111_1111 -> each reg holds its value and exactly 8 reg_wr_en pulses occur.
- rst_n pulled low while in RESP -> bvalid=0 asynchronously and all regs=RESET_VAL. With WSTRB_EN: reg3=32'h1234_5678, write 32'hAABB_CCDD with wstrb=4'b0101 -> reg3=32'h12BB_56DD.

Source files
------------

// File: rtl/lite_write_slave_if.sv
// AXI-Lite write channel bundle (AW, W, B) between the DMA write master and
// lite_write_slave. The byte-enable signal exists only when
// LITE_WRITE_SLAVE_WSTRB_EN is defined.
interface lite_write_slave_if #(
    parameter int unsigned ADDR_W = 10
);
    logic [ADDR_W-1:0] s_axi_lite_awaddr;
    logic              s_axi_lite_awvalid;
    logic              s_axi_lite_awready;
    logic [31:0]       s_axi_lite_wdata;
`ifdef LITE_WRITE_SLAVE_WSTRB_EN
    logic [3:0]        s_axi_lite_wstrb;
`endif
    logic              s_axi_lite_wvalid;
    logic              s_axi_lite_wready;
    logic [1:0]        s_axi_lite_bresp;
    logic              s_axi_lite_bvalid;
    logic              s_axi_lite_bready;

    modport slave (
`ifdef LITE_WRITE_SLAVE_WSTRB_EN
        input  s_axi_lite_wstrb,
`endif
        input  s_axi_lite_awaddr,
        input  s_axi_lite_awvalid,
        output s_axi_lite_awready,
        input  s_axi_lite_wdata,
        input  s_axi_lite_wvalid,
        output s_axi_lite_wready,
        output s_axi_lite_bresp,
        output s_axi_lite_bvalid,
        input  s_axi_lite_bready
    );

    modport master (
`ifdef LITE_WRITE_SLAVE_WSTRB_EN
        output s_axi_lite_wstrb,
`endif
        output s_axi_lite_awaddr,
        output s_axi_lite_awvalid,
        input  s_axi_lite_awready,
        output s_axi_lite_wdata,
        output s_axi_lite_wvalid,
        input  s_axi_lite_wready,
        input  s_axi_lite_bresp,
        input  s_axi_lite_bvalid,
        output s_axi_lite_bready
    );
endinterface

// File: rtl/lite_write_slave.sv
// AXI-Lite write responder with an internal 32-bit register bank.
// AW and W are accepted independently (either order or together), the word is
// committed in a single COMMIT cycle, then a response is held on B until taken.
// Only one transaction is in flight at a time.
// Optional feature: define LITE_WRITE_SLAVE_WSTRB_EN to add byte enables.
module lite_write_slave #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000,
    localparam int unsigned IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lite_write_slave_if.slave     s_axi_lite,
    output logic                  reg_wr_en,
    output logic [IDX_W-1:0]      reg_wr_idx,
    output logic [31:0]           reg_wr_data,
    output logic [NUM_REGS*32-1:0] regs_flat
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'b001,
        S_COMMIT = 3'b010,
        S_RESP   = 3'b100
    } state_e;

    state_e            state_q, state_d;
    logic              alive_q;
    logic              aw_got_q, aw_got_d;
    logic              w_got_q, w_got_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
`ifdef LITE_WRITE_SLAVE_WSTRB_EN
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       cur_word;
`endif
    logic [1:0]        bresp_q, bresp_d;
    logic              wr_en_q, wr_en_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [31:0]       wr_data_q, wr_data_d;

    logic [31:0]       regs_q [NUM_REGS];
    logic              awready, wready, bvalid;
    logic              aw_hs, w_hs;
    logic              addr_ok, wr_any, reg_we;
    logic [IDX_W-1:0]  idx_sel;
    logic [31:0]       merged;

    // Decode the latched address and build the word that would be committed.
    always_comb begin
        idx_sel = addr_q[IDX_W+1:2];
        addr_ok = (addr_q[1:0] == 2'b00) && (32'(addr_q[ADDR_W-1:2]) < NUM_REGS);
`ifdef LITE_WRITE_SLAVE_WSTRB_EN
        cur_word = regs_q[idx_sel];
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = wstrb_q[b] ? wdata_q[8*b +: 8] : cur_word[8*b +: 8];
        end
        wr_any = |wstrb_q;
`else
        merged = wdata_q;
        wr_any = 1'b1;
`endif
    end

    // Next-state and handshake outputs of the IDLE/COMMIT/RESP controller.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d   = state_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
`ifdef LITE_WRITE_SLAVE_WSTRB_EN
        wstrb_d   = wstrb_q;
`endif
        bresp_d   = bresp_q;
        wr_en_d   = 1'b0;
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        reg_we    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                awready = alive_q && !aw_got_q;
                wready  = alive_q && !w_got_q;
                aw_hs   = s_axi_lite.s_axi_lite_awvalid && awready;
                w_hs    = s_axi_lite.s_axi_lite_wvalid && wready;
                if (aw_hs) begin
                    addr_d   = s_axi_lite.s_axi_lite_awaddr;
                    aw_got_d = 1'b1;
                end
                if (w_hs) begin
                    wdata_d = s_axi_lite.s_axi_lite_wdata;
`ifdef LITE_WRITE_SLAVE_WSTRB_EN
                    wstrb_d = s_axi_lite.s_axi_lite_wstrb;
`endif
                    w_got_d = 1'b1;
                end
                // Look at the updated flags so simultaneous handshakes commit next cycle.
                if (aw_got_d && w_got_d) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                aw_got_d = 1'b0;
                w_got_d  = 1'b0;
                state_d  = S_RESP;
                if (addr_ok) begin
                    bresp_d = RESP_OKAY;
                    if (wr_any) begin
                        reg_we    = 1'b1;
                        wr_en_d   = 1'b1;
                        wr_idx_d  = idx_sel;
                        wr_data_d = merged;
                    end
                end else begin
                    bresp_d = RESP_SLVERR;
                end
            end
            S_RESP: begin
                bvalid = 1'b1;
                if (s_axi_lite.s_axi_lite_bready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Controller state, latched transaction and write-strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process ordering.
        if (!rst_n) begin
            state_q   <= S_IDLE;
            alive_q   <= 1'b0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
`ifdef LITE_WRITE_SLAVE_WSTRB_EN
            wstrb_q   <= '0;
`endif
            bresp_q   <= RESP_OKAY;
            wr_en_q   <= 1'b0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            alive_q   <= 1'b1;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
`ifdef LITE_WRITE_SLAVE_WSTRB_EN
            wstrb_q   <= wstrb_d;
`endif
            bresp_q   <= bresp_d;
            wr_en_q   <= wr_en_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Register bank, written only from the COMMIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the bank is architecturally visible and must come up at RESET_VAL,
        // so it is built from reset flops rather than an unreset RAM.
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else if (reg_we) begin
            regs_q[idx_sel] <= merged;
        end
    end

    // Flatten the bank for the DMA core.
    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs_flat[32*i +: 32] = regs_q[i];
        end
    end

    assign s_axi_lite.s_axi_lite_awready = awready;
    assign s_axi_lite.s_axi_lite_wready  = wready;
    assign s_axi_lite.s_axi_lite_bvalid  = bvalid;
    assign s_axi_lite.s_axi_lite_bresp   = bresp_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_wr_idx  = wr_idx_q;
    assign reg_wr_data = wr_data_q;

endmodule

// File: tb/tb_lite_write_slave.sv
// Scoreboard bench for lite_write_slave: each write pushes its expected
// register strobe and B response; a monitor pops and compares them as the DUT
// produces them. Define LITE_WRITE_SLAVE_WSTRB_EN to exercise byte enables.
module tb_lite_write_slave;

    localparam int          ADDR_W    = 10;
    localparam int          NUM_REGS  = 16;
    localparam logic [31:0] RESET_VAL = 32'h0000_0000;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    reg_wr_en;
    logic [3:0]              reg_wr_idx;
    logic [31:0]             reg_wr_data;
    logic [NUM_REGS*32-1:0]  regs_flat;

    always #5 clk = ~clk;

    lite_write_slave_if #(.ADDR_W(ADDR_W)) bus ();

    lite_write_slave #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .RESET_VAL(RESET_VAL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_axi_lite (bus),
        .reg_wr_en  (reg_wr_en),
        .reg_wr_idx (reg_wr_idx),
        .reg_wr_data(reg_wr_data),
        .regs_flat  (regs_flat)
    );

    typedef struct {
        int unsigned idx;
        logic [31:0] data;
    } wr_t;

    int          nvec   = 0;
    int          nerr   = 0;
    int          cyc    = 0;
    int          pulses = 0;
    wr_t         exp_wr[$];
    logic [1:0]  exp_resp[$];
    logic [31:0] model[NUM_REGS];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares register strobes and B handshakes against the queues.
    always @(negedge clk) begin
        wr_t        e;
        logic [1:0] r;
        #2;
        if (rst_n) begin
            if (reg_wr_en) begin
                pulses++;
                nvec++;
                if (exp_wr.size() == 0) begin
                    nerr++;
                    $display("FAIL wr_strobe: got idx=%0d data=%h, expected no write", reg_wr_idx, reg_wr_data);
                end else begin
                    e = exp_wr.pop_front();
                    if (reg_wr_idx !== e.idx[3:0] || reg_wr_data !== e.data) begin
                        nerr++;
                        $display("FAIL wr_strobe: got idx=%0d data=%h, expected idx=%0d data=%h",
                                 reg_wr_idx, reg_wr_data, e.idx, e.data);
                    end
                end
            end
            if (bus.s_axi_lite_bvalid && bus.s_axi_lite_bready) begin
                nvec++;
                if (exp_resp.size() == 0) begin
                    nerr++;
                    $display("FAIL b_resp: got bresp=%b, expected no response", bus.s_axi_lite_bresp);
                end else begin
                    r = exp_resp.pop_front();
                    if (bus.s_axi_lite_bresp !== r) begin
                        nerr++;
                        $display("FAIL b_resp: got bresp=%b, expected %b", bus.s_axi_lite_bresp, r);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected the test sequence to complete");
        $fatal(1, "watchdog");
    end

    // Issue one write; AW and W valids rise after their own delays.
    task automatic do_write(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, output int last_hs);
        bit          aw_done = 0;
        bit          w_done  = 0;
        bit          aw_hs, w_hs;
        int          k = 0;
        int unsigned idx;
        logic [31:0] m;
        idx = 32'(addr[9:2]);
        if (addr[1:0] == 2'b00 && idx < NUM_REGS) begin
`ifdef LITE_WRITE_SLAVE_WSTRB_EN
            m = model[idx];
            for (int b = 0; b < 4; b++) if (strb[b]) m[8*b +: 8] = data[8*b +: 8];
            if (strb != 4'b0000) begin
                exp_wr.push_back('{idx, m});
                model[idx] = m;
            end
`else
            m = data;
            exp_wr.push_back('{idx, m});
            model[idx] = m;
`endif
            exp_resp.push_back(2'b00);
        end else begin
            exp_resp.push_back(2'b10);
        end
        last_hs = -1;
        while (!(aw_done && w_done) && k < 50) begin
            @(negedge clk);
            bus.s_axi_lite_awaddr  = addr;
            bus.s_axi_lite_wdata   = data;
`ifdef LITE_WRITE_SLAVE_WSTRB_EN
            bus.s_axi_lite_wstrb   = strb;
`endif
            bus.s_axi_lite_awvalid = !aw_done && k >= aw_dly;
            bus.s_axi_lite_wvalid  = !w_done && k >= w_dly;
            #1;
            aw_hs = bus.s_axi_lite_awvalid && bus.s_axi_lite_awready;
            w_hs  = bus.s_axi_lite_wvalid && bus.s_axi_lite_wready;
            if (aw_hs || w_hs) last_hs = cyc;
            @(posedge clk);
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done  = 1;
            k++;
        end
        @(negedge clk);
        bus.s_axi_lite_awvalid = 1'b0;
        bus.s_axi_lite_wvalid  = 1'b0;
        #1;
        nvec++;
        if (!(aw_done && w_done)) begin
            nerr++;
            $display("FAIL handshake_timeout: got aw_done=%0d w_done=%0d, expected both 1", aw_done, w_done);
        end
    endtask

    task automatic wait_b(output int first);
        first = -1;
        for (int i = 0; i < 20; i++) begin
            if (bus.s_axi_lite_bvalid) begin
                first = cyc;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int i = 0;
        while (exp_resp.size() != 0 && i < 100) begin
            @(negedge clk);
            #1;
            i++;
        end
        @(negedge clk);
        #1;
        nvec++;
        if (exp_resp.size() != 0) begin
            nerr++;
            $display("FAIL drain: got %0d responses outstanding, expected 0", exp_resp.size());
        end
    endtask

    task automatic check_regs(input string name);
        for (int i = 0; i < NUM_REGS; i++) begin
            nvec++;
            if (regs_flat[32*i +: 32] !== model[i]) begin
                nerr++;
                $display("FAIL %s reg%0d: got %h, expected %h", name, i, regs_flat[32*i +: 32], model[i]);
            end
        end
    endtask

    task automatic test_reset();
        bus.s_axi_lite_awaddr  = '0;
        bus.s_axi_lite_awvalid = 1'b0;
        bus.s_axi_lite_wdata   = '0;
        bus.s_axi_lite_wvalid  = 1'b0;
        bus.s_axi_lite_bready  = 1'b0;
`ifdef LITE_WRITE_SLAVE_WSTRB_EN
        bus.s_axi_lite_wstrb   = 4'hF;
`endif
        for (int i = 0; i < NUM_REGS; i++) model[i] = RESET_VAL;
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({bus.s_axi_lite_awready, bus.s_axi_lite_wready, bus.s_axi_lite_bvalid,
             bus.s_axi_lite_bresp, reg_wr_en} !== 6'b0) begin
            nerr++;
            $display("FAIL reset_ctrl: got awready=%b wready=%b bvalid=%b bresp=%b wr_en=%b, expected all 0",
                     bus.s_axi_lite_awready, bus.s_axi_lite_wready, bus.s_axi_lite_bvalid,
                     bus.s_axi_lite_bresp, reg_wr_en);
        end
        nvec++;
        if (reg_wr_idx !== 4'd0 || reg_wr_data !== 32'd0) begin
            nerr++;
            $display("FAIL reset_strobe: got idx=%0d data=%h, expected 0/0", reg_wr_idx, reg_wr_data);
        end
        check_regs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        nvec++;
        if (bus.s_axi_lite_awready !== 1'b1 || bus.s_axi_lite_wready !== 1'b1) begin
            nerr++;
            $display("FAIL idle_ready: got awready=%b wready=%b, expected 1/1",
                     bus.s_axi_lite_awready, bus.s_axi_lite_wready);
        end
    endtask

    task automatic test_aw_then_w();
        int hs, f;
        bus.s_axi_lite_bready = 1'b1;
        do_write(10'h008, 32'hDEAD_BEEF, 4'hF, 0, 3, hs);
        wait_b(f);
        nvec++;
        if (f !== hs + 2) begin
            nerr++;
            $display("FAIL aw_then_w_latency: got bvalid at cycle %0d, expected %0d", f, hs + 2);
        end
        drain();
        nvec++;
        if (regs_flat[95:64] !== 32'hDEAD_BEEF) begin
            nerr++;
            $display("FAIL aw_then_w_reg2: got %h, expected deadbeef", regs_flat[95:64]);
        end
        check_regs("aw_then_w");
    endtask

    task automatic test_w_first_and_same_cycle();
        int hs, f;
        do_write(10'h000, 32'h0000_0001, 4'hF, 2, 0, hs);
        drain();
        do_write(10'h004, 32'h0000_0002, 4'hF, 0, 0, hs);
        wait_b(f);
        nvec++;
        if (f !== hs + 2) begin
            nerr++;
            $display("FAIL same_cycle_latency: got bvalid at cycle %0d, expected %0d", f, hs + 2);
        end
        drain();
        check_regs("w_first_same_cycle");
    endtask

    task automatic test_out_of_range();
        int hs, p0;
        p0 = pulses;
        do_write(10'h040, 32'hFFFF_FFFF, 4'hF, 0, 0, hs);
        drain();
        do_write(10'h005, 32'h1234_0000, 4'hF, 1, 0, hs);
        drain();
        do_write(10'h3FC, 32'h5A5A_5A5A, 4'hF, 0, 1, hs);
        drain();
        nvec++;
        if (pulses !== p0) begin
            nerr++;
            $display("FAIL out_of_range_pulses: got %0d strobes, expected 0", pulses - p0);
        end
        check_regs("out_of_range");
    endtask

    task automatic test_backpressure();
        int hs, f;
        bus.s_axi_lite_bready = 1'b0;
        do_write(10'h00C, 32'hCAFE_F00D, 4'hF, 0, 0, hs);
        wait_b(f);
        for (int i = 0; i < 5; i++) begin
            nvec++;
            if (bus.s_axi_lite_bvalid !== 1'b1 || bus.s_axi_lite_bresp !== 2'b00 ||
                bus.s_axi_lite_awready !== 1'b0 || bus.s_axi_lite_wready !== 1'b0) begin
                nerr++;
                $display("FAIL backpressure_hold: got bvalid=%b bresp=%b awready=%b wready=%b, expected 1/00/0/0",
                         bus.s_axi_lite_bvalid, bus.s_axi_lite_bresp,
                         bus.s_axi_lite_awready, bus.s_axi_lite_wready);
            end
            @(negedge clk);
            #1;
        end
        bus.s_axi_lite_bready = 1'b1;
        @(negedge clk);
        #1;
        nvec++;
        if (bus.s_axi_lite_bvalid !== 1'b0 || bus.s_axi_lite_awready !== 1'b1) begin
            nerr++;
            $display("FAIL backpressure_release: got bvalid=%b awready=%b, expected 0/1",
                     bus.s_axi_lite_bvalid, bus.s_axi_lite_awready);
        end
        drain();
        check_regs("backpressure");
    endtask

    task automatic test_back_to_back();
        int          hs, p0;
        logic [31:0] d;
        p0 = pulses;
        bus.s_axi_lite_bready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = 32'(i) * 32'h1111_1111;
            do_write(10'(i * 4), d, 4'hF, 0, 0, hs);
        end
        drain();
        nvec++;
        if (pulses - p0 !== 8) begin
            nerr++;
            $display("FAIL back_to_back_pulses: got %0d strobes, expected 8", pulses - p0);
        end
        check_regs("back_to_back");
    endtask

`ifdef LITE_WRITE_SLAVE_WSTRB_EN
    task automatic test_wstrb();
        int hs, p0;
        do_write(10'h00C, 32'h1234_5678, 4'hF, 0, 0, hs);
        drain();
        do_write(10'h00C, 32'hAABB_CCDD, 4'b0101, 0, 0, hs);
        drain();
        nvec++;
        if (regs_flat[127:96] !== 32'h12BB_56DD) begin
            nerr++;
            $display("FAIL wstrb_merge: got %h, expected 12bb56dd", regs_flat[127:96]);
        end
        p0 = pulses;
        do_write(10'h00C, 32'hFFFF_FFFF, 4'b0000, 0, 0, hs);
        drain();
        nvec++;
        if (pulses !== p0) begin
            nerr++;
            $display("FAIL wstrb_zero: got %0d strobes, expected 0", pulses - p0);
        end
        check_regs("wstrb");
    endtask
`endif

    task automatic test_reset_mid();
        int hs, f;
        bus.s_axi_lite_bready = 1'b0;
        do_write(10'h010, 32'h5555_AAAA, 4'hF, 0, 0, hs);
        wait_b(f);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        exp_resp.delete();
        for (int i = 0; i < NUM_REGS; i++) model[i] = RESET_VAL;
        #1;
        nvec++;
        if (bus.s_axi_lite_bvalid !== 1'b0 || bus.s_axi_lite_awready !== 1'b0 || reg_wr_en !== 1'b0) begin
            nerr++;
            $display("FAIL reset_mid_ctrl: got bvalid=%b awready=%b wr_en=%b, expected 0/0/0",
                     bus.s_axi_lite_bvalid, bus.s_axi_lite_awready, reg_wr_en);
        end
        check_regs("reset_mid");
        bus.s_axi_lite_bready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            nvec++;
            if (bus.s_axi_lite_bvalid !== 1'b0) begin
                nerr++;
                $display("FAIL reset_mid_no_resp: got bvalid=%b, expected 0", bus.s_axi_lite_bvalid);
            end
        end
        do_write(10'h004, 32'h0000_0077, 4'hF, 0, 0, hs);
        drain();
        check_regs("after_reset");
    endtask

    initial begin
        test_reset();
        test_aw_then_w();
        test_w_first_and_same_cycle();
        test_out_of_range();
        test_backpressure();
        test_back_to_back();
`ifdef LITE_WRITE_SLAVE_WSTRB_EN
        test_wstrb();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
